// File: rtl/hdc_stream_encoder_pkg.sv
// Shared constants and types for the streaming HDC text encoder: symbol map
// offsets, ternary output codes and the encoder state enum.
package hdc_pkg;

   localparam int NUM_CHAR   = 37;
   localparam int SYM_W      = 6;
   localparam int SYM_OTHER  = 0;
   localparam int SYM_DIGIT0 = 1;
   localparam int SYM_ALPHA0 = 11;

   localparam logic [1:0] TRI_POS  = 2'b01;
   localparam logic [1:0] TRI_NEG  = 2'b11;
   localparam logic [1:0] TRI_ZERO = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_SUM   = 2'd2,
      ST_EMIT  = 2'd3
   } state_e;

endpackage

// File: rtl/hdc_char_tokenizer.sv
// Combinational ASCII -> symbol map; upper case folds onto lower case and
// anything outside [0-9a-z] becomes the "other" symbol.
module hdc_char_tokenizer
   import hdc_pkg::*;
(
   input  logic [7:0]       ch,
   output logic [SYM_W-1:0] sym
);

   logic [7:0] lower;
   logic [7:0] sym_wide;

   always_comb begin
      lower    = ch;
      sym_wide = 8'(SYM_OTHER);
      if (ch >= 8'h41 && ch <= 8'h5A) begin
         lower = ch + 8'h20;
      end
      if (lower >= 8'h61 && lower <= 8'h7A) begin
         sym_wide = lower - 8'h61 + 8'(SYM_ALPHA0);
      end else if (lower >= 8'h30 && lower <= 8'h39) begin
         sym_wide = lower - 8'h30 + 8'(SYM_DIGIT0);
      end
   end

   assign sym = sym_wide[SYM_W-1:0];

endmodule

// File: rtl/hdc_stream_encoder.sv
// Streaming HDC encoder: bundles item-memory hypervectors of each message
// character into saturating counters, then emits a mean-thresholded HV.
module hdc_stream_encoder
   import hdc_pkg::*;
#(
   parameter  int DIM     = 128,
   parameter  int LANES   = 16,
   parameter  int CNT_W   = 8,
   parameter  int MAX_LEN = 160,
   localparam int NCHUNK  = DIM / LANES,
   localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 im_we,
   input  logic [5:0]           im_sym,
   input  logic [CHUNK_W-1:0]   im_chunk,
   input  logic [LANES-1:0]     im_wdata,
   input  logic                 bin_mode,
   input  logic                 ch_valid,
   output logic                 ch_ready,
   input  logic [7:0]           ch_data,
   input  logic                 ch_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*LANES-1:0]   out_data,
   output logic                 out_last,
   output logic                 sat_flag,
   output logic                 ovf_flag
);

   localparam int SUM_W    = CNT_W + $clog2(DIM);
   localparam int PROD_W   = SUM_W + 1;
   localparam int LEN_W    = $clog2(MAX_LEN + 2);
   localparam int IM_DEPTH = NUM_CHAR * NCHUNK;
   localparam int IM_AW    = $clog2(IM_DEPTH);

   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
   localparam logic [LEN_W-1:0]   LEN_LIMIT  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]   LEN_SAT    = LEN_W'(MAX_LEN + 1);
   localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(NCHUNK - 1);

   state_e             state_q, state_d;
   logic [CHUNK_W-1:0] chunk_q, chunk_d;
   logic [SYM_W-1:0]   sym_q, sym_d;
   logic               last_q, last_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic               sat_q, sat_d;
   logic               ovf_q, ovf_d;
   logic               bin_q, bin_d;
   logic [CNT_W-1:0]   cnt_q [NCHUNK][LANES];
   logic [CNT_W-1:0]   cnt_d [NCHUNK][LANES];

   logic [LANES-1:0]   im_mem [IM_DEPTH];
   logic [LANES-1:0]   im_rdata;
   logic [IM_AW-1:0]   im_raddr;
   logic [IM_AW-1:0]   im_waddr;
   logic               im_wr_en;

   logic [SYM_W-1:0]   tok_sym;
   logic [LEN_W-1:0]   len_inc;
   logic [SUM_W-1:0]   lane_sum;
   logic               chunk_end;

   hdc_char_tokenizer u_tokenizer (
      .ch  (ch_data),
      .sym (tok_sym)
   );

   assign ch_ready  = (state_q == ST_IDLE);
   assign chunk_end = (chunk_q == CHUNK_LAST);
   assign len_inc   = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;

   // Item memory keeps its contents through reset; a character beat wins over a write.
   assign im_raddr = IM_AW'(sym_q) * IM_AW'(NCHUNK) + IM_AW'(chunk_q);
   assign im_waddr = IM_AW'(im_sym) * IM_AW'(NCHUNK) + IM_AW'(im_chunk);
   assign im_wr_en = im_we && (state_q == ST_IDLE) && !ch_valid && (im_sym < SYM_W'(NUM_CHAR));
   assign im_rdata = im_mem[im_raddr];

   always_ff @(posedge clk) begin
      if (im_wr_en) begin
         im_mem[im_waddr] <= im_wdata;
      end
   end

   always_comb begin
      lane_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_sum = lane_sum + SUM_W'(cnt_q[chunk_q][k]);
      end
   end

   always_comb begin
      state_d = state_q;
      chunk_d = chunk_q;
      sym_d   = sym_q;
      last_d  = last_q;
      len_d   = len_q;
      sum_d   = sum_q;
      sat_d   = sat_q;
      ovf_d   = ovf_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (ch_valid) begin
               if (len_q == '0) begin
                  sat_d = 1'b0;
                  ovf_d = 1'b0;
                  bin_d = bin_mode;
               end
               len_d   = len_inc;
               sym_d   = tok_sym;
               last_d  = ch_last;
               chunk_d = '0;
               // Characters beyond the length limit are consumed but never bundled.
               if (len_inc > LEN_LIMIT) begin
                  ovf_d = 1'b1;
                  if (ch_last) begin
                     state_d = ST_SUM;
                  end
               end else begin
                  state_d = ST_ACCUM;
               end
            end
         end
         ST_ACCUM: begin
            for (int k = 0; k < LANES; k++) begin
               if (im_rdata[k]) begin
                  if (cnt_q[chunk_q][k] == CNT_MAX) begin
                     sat_d = 1'b1;
                  end else begin
                     cnt_d[chunk_q][k] = cnt_q[chunk_q][k] + 1'b1;
                  end
               end
            end
            chunk_d = chunk_q + 1'b1;
            if (chunk_end) begin
               chunk_d = '0;
               state_d = last_q ? ST_SUM : ST_IDLE;
            end
         end
         ST_SUM: begin
            sum_d   = sum_q + lane_sum;
            chunk_d = chunk_q + 1'b1;
            if (chunk_end) begin
               chunk_d = '0;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               for (int k = 0; k < LANES; k++) begin
                  cnt_d[chunk_q][k] = '0;
               end
               chunk_d = chunk_q + 1'b1;
               if (chunk_end) begin
                  chunk_d = '0;
                  sum_d   = '0;
                  len_d   = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Mean threshold without division: compare cnt*DIM against the total sum.
   always_comb begin
      out_data = '0;
      if (state_q == ST_EMIT) begin
         for (int k = 0; k < LANES; k++) begin
            if ((PROD_W'(cnt_q[chunk_q][k]) * PROD_W'(DIM)) > PROD_W'(sum_q)) begin
               out_data[2*k +: 2] = TRI_POS;
            end else if ((PROD_W'(cnt_q[chunk_q][k]) * PROD_W'(DIM)) < PROD_W'(sum_q)) begin
               out_data[2*k +: 2] = bin_q ? TRI_ZERO : TRI_NEG;
            end
         end
      end
   end

   assign out_valid = (state_q == ST_EMIT);
   assign out_last  = (state_q == ST_EMIT) && chunk_end;
   assign sat_flag  = sat_q;
   assign ovf_flag  = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         chunk_q <= '0;
         sym_q   <= '0;
         last_q  <= 1'b0;
         len_q   <= '0;
         sum_q   <= '0;
         sat_q   <= 1'b0;
         ovf_q   <= 1'b0;
         bin_q   <= 1'b0;
         cnt_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         chunk_q <= chunk_d;
         sym_q   <= sym_d;
         last_q  <= last_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         sat_q   <= sat_d;
         ovf_q   <= ovf_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hdc_stream_encoder.sv
// Directed bench for hdc_stream_encoder; small CNT_W and MAX_LEN make
// saturation and overflow reachable with short messages.
module tb_hdc_stream_encoder;

   localparam int DIM     = 128;
   localparam int LANES   = 16;
   localparam int NCHUNK  = 8;
   localparam int CNT_W   = 2;
   localparam int MAX_LEN = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        im_we = 1'b0;
   logic [5:0]  im_sym = '0;
   logic [2:0]  im_chunk = '0;
   logic [15:0] im_wdata = '0;
   logic        bin_mode = 1'b0;
   logic        ch_valid = 1'b0;
   logic        ch_ready;
   logic [7:0]  ch_data = '0;
   logic        ch_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_last;
   logic        sat_flag;
   logic        ovf_flag;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] rx_data [NCHUNK];
   logic        rx_last [NCHUNK];
   int          rx_waits;
   logic        rx_timeout;

   hdc_stream_encoder #(
      .DIM     (DIM),
      .LANES   (LANES),
      .CNT_W   (CNT_W),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .im_we     (im_we),
      .im_sym    (im_sym),
      .im_chunk  (im_chunk),
      .im_wdata  (im_wdata),
      .bin_mode  (bin_mode),
      .ch_valid  (ch_valid),
      .ch_ready  (ch_ready),
      .ch_data   (ch_data),
      .ch_last   (ch_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .sat_flag  (sat_flag),
      .ovf_flag  (ovf_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic load_sym(input logic [5:0] sym, input logic [15:0] word);
      for (int c = 0; c < NCHUNK; c++) begin
         im_we    = 1'b1;
         im_sym   = sym;
         im_chunk = 3'(c);
         im_wdata = word;
         @(negedge clk);
      end
      im_we = 1'b0;
   endtask

   task automatic load_onehot(input logic [5:0] sym);
      for (int c = 0; c < NCHUNK; c++) begin
         im_we    = 1'b1;
         im_sym   = sym;
         im_chunk = 3'(c);
         im_wdata = 16'h0001 << c;
         @(negedge clk);
      end
      im_we = 1'b0;
   endtask

   task automatic send_char(input logic [7:0] ch, input logic last);
      int n;
      n        = 0;
      ch_valid = 1'b1;
      ch_data  = ch;
      ch_last  = last;
      while (!ch_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ch_ready) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL accept_timeout: ch_ready got %b required 1", ch_ready);
      end
      @(negedge clk);
      ch_valid = 1'b0;
      ch_last  = 1'b0;
   endtask

   task automatic get_hv();
      int n;
      n          = 0;
      rx_timeout = 1'b0;
      out_ready  = 1'b1;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      rx_waits = n;
      if (!out_valid) begin
         rx_timeout = 1'b1;
         return;
      end
      for (int b = 0; b < NCHUNK; b++) begin
         rx_data[b] = out_data;
         rx_last[b] = out_last;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if (ch_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ch_ready: got %b required 1", ch_ready); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
      n_checks++;
      if ({sat_flag, ovf_flag} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_flags: got %b required 00", {sat_flag, ovf_flag}); end
      n_checks++;
      if ({out_data, out_last} !== 33'd0) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h/%b required 0/0", out_data, out_last); end
      rst_n = 1'b1;
      @(negedge clk);
      load_sym(6'd11, 16'hAAAA);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Item memory loaded before the reset pulse must still drive this message.
   task automatic test_ternary();
      bin_mode = 1'b0;
      send_char("A", 1'b1);
      get_hv();
      n_checks++;
      if (rx_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL tern_timeout: got %b required 0", rx_timeout); end
      n_checks++;
      if (rx_waits != 16) begin n_fail++; $display("[TB] FAIL tern_latency: got %0d required 16 cycles after accept edge", rx_waits); end
      for (int b = 0; b < NCHUNK; b++) begin
         n_checks++;
         if (rx_data[b] !== 32'h77777777) begin n_fail++; $display("[TB] FAIL tern_data beat %0d: got %h required 77777777", b, rx_data[b]); end
         n_checks++;
         if (rx_last[b] !== (b == NCHUNK - 1)) begin n_fail++; $display("[TB] FAIL tern_last beat %0d: got %b required %b", b, rx_last[b], (b == NCHUNK - 1)); end
      end
      n_checks++;
      if ({sat_flag, ovf_flag} !== 2'b00) begin n_fail++; $display("[TB] FAIL tern_flags: got %b required 00", {sat_flag, ovf_flag}); end
   endtask

   task automatic test_binary();
      bin_mode = 1'b1;
      send_char("a", 1'b1);
      bin_mode = 1'b0;
      get_hv();
      n_checks++;
      if (rx_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL bin_timeout: got %b required 0", rx_timeout); end
      for (int b = 0; b < NCHUNK; b++) begin
         n_checks++;
         if (rx_data[b] !== 32'h44444444) begin n_fail++; $display("[TB] FAIL bin_data beat %0d: got %h required 44444444", b, rx_data[b]); end
      end
   endtask

   task automatic test_tokenise();
      load_sym(6'd36, 16'hFFFF);
      load_sym(6'd10, 16'h00FF);
      load_sym(6'd0, 16'h0000);
      send_char("Z", 1'b0);
      send_char("9", 1'b0);
      send_char("!", 1'b1);
      get_hv();
      n_checks++;
      if (rx_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL tok_timeout: got %b required 0", rx_timeout); end
      for (int b = 0; b < NCHUNK; b++) begin
         n_checks++;
         if (rx_data[b] !== 32'hFFFF5555) begin n_fail++; $display("[TB] FAIL tok_data beat %0d: got %h required FFFF5555", b, rx_data[b]); end
      end
   endtask

   // One set dimension per chunk makes every beat distinct, so a lost or repeated beat shows.
   task automatic test_backpressure();
      int n;
      logic [31:0] exp;
      load_onehot(6'd1);
      send_char("0", 1'b1);
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_timeout: out_valid got %b required 1", out_valid); end
      for (int b = 0; b < NCHUNK; b++) begin
         exp = ~(32'h2 << (2 * b));
         if (b == 3) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               n_checks++;
               if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, exp}) begin
                  n_fail++;
                  $display("[TB] FAIL bp_stall: got v=%b l=%b d=%h required v=1 l=0 d=%h", out_valid, out_last, out_data, exp);
               end
            end
            out_ready = 1'b1;
         end
         n_checks++;
         if ({out_valid, out_last, out_data} !== {1'b1, (b == NCHUNK - 1), exp}) begin
            n_fail++;
            $display("[TB] FAIL bp_beat %0d: got v=%b l=%b d=%h required v=1 l=%b d=%h", b, out_valid, out_last, out_data, (b == NCHUNK - 1), exp);
         end
         @(negedge clk);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_extra_beat: out_valid got %b required 0", out_valid); end
   endtask

   task automatic test_saturation();
      load_sym(6'd11, 16'hFFFF);
      for (int i = 0; i < 5; i++) begin
         send_char("a", (i == 4));
      end
      get_hv();
      n_checks++;
      if (rx_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_timeout: got %b required 0", rx_timeout); end
      for (int b = 0; b < NCHUNK; b++) begin
         n_checks++;
         if (rx_data[b] !== 32'h0) begin n_fail++; $display("[TB] FAIL sat_data beat %0d: got %h required 00000000", b, rx_data[b]); end
      end
      n_checks++;
      if ({sat_flag, ovf_flag} !== 2'b11) begin n_fail++; $display("[TB] FAIL sat_flags: got %b required 11", {sat_flag, ovf_flag}); end
   endtask

   // Two trailing 'z' beats would push counters into saturation if they were bundled.
   task automatic test_overflow_abort();
      load_sym(6'd11, 16'hAAAA);
      send_char("9", 1'b0);
      send_char("a", 1'b0);
      send_char("!", 1'b0);
      send_char("!", 1'b0);
      send_char("z", 1'b0);
      send_char("z", 1'b1);
      get_hv();
      n_checks++;
      if (rx_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_timeout: got %b required 0", rx_timeout); end
      for (int b = 0; b < NCHUNK; b++) begin
         n_checks++;
         if (rx_data[b] !== 32'h33334444) begin n_fail++; $display("[TB] FAIL ovf_data beat %0d: got %h required 33334444", b, rx_data[b]); end
      end
      n_checks++;
      if ({sat_flag, ovf_flag} !== 2'b01) begin n_fail++; $display("[TB] FAIL ovf_flags: got %b required 01", {sat_flag, ovf_flag}); end

      send_char("a", 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ch_ready, out_valid, sat_flag, ovf_flag} !== 4'b1000) begin
         n_fail++;
         $display("[TB] FAIL abort_state: got rdy/vld/sat/ovf=%b required 1000", {ch_ready, out_valid, sat_flag, ovf_flag});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_char("!", 1'b1);
      get_hv();
      n_checks++;
      if (rx_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_timeout: got %b required 0", rx_timeout); end
      for (int b = 0; b < NCHUNK; b++) begin
         n_checks++;
         if (rx_data[b] !== 32'h0) begin n_fail++; $display("[TB] FAIL abort_discard beat %0d: got %h required 00000000", b, rx_data[b]); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_ternary();
      test_binary();
      test_tokenise();
      test_backpressure();
      test_saturation();
      test_overflow_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
